// File: rtl/gpio_pkg.sv
// Shared GPIO constants: register map, direction encoding, per-pin edge event payload.
// Consumed by gpio_in_cond and gpio_debounce_bit.
package gpio_pkg;

    localparam int unsigned GPIO_WIDTH = 32;

    localparam logic [31:0] GPIO_BASE     = 32'h2000_0000;
    localparam logic [31:0] GPIO_OFS_DATA = 32'h0000_0000;
    localparam logic [31:0] GPIO_OFS_DIR  = 32'h0000_0004;
    localparam logic [31:0] GPIO_OFS_READ = 32'h0000_0008;

    localparam logic DIR_OUT = 1'b1;
    localparam logic DIR_IN  = 1'b0;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_evt_t;

    // Counter width holding values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: 2-flop synchroniser, tick-driven debounce counter, stable level and edge events.
// GPIO_COND_GLITCH_CNT_EN adds the glitch_c rejected-glitch indicator.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int unsigned DB_COUNT = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      pad_i,
    input  logic      dir_i,
    input  logic      tick_i,
    output logic      level_o,
    output edge_evt_t evt_o
`ifdef GPIO_COND_GLITCH_CNT_EN
    ,
    output logic      glitch_c
`endif
);

    localparam int unsigned CW = cnt_width(DB_COUNT + 1);

    logic            s1_q;
    logic            s2_q;
    logic            stable_q;
    logic            stable_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    edge_evt_t       evt_q;
    edge_evt_t       evt_d;
    logic            accept;

    // A differing level must survive DB_COUNT ticks; any return to stable restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        evt_d    = '0;
        accept   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CW'(DB_COUNT - 1)) begin
                accept   = 1'b1;
                stable_d = s2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (accept && (dir_i == DIR_IN)) begin
            evt_d.rise = s2_q;
            evt_d.fall = ~s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            evt_q    <= '0;
        end else begin
            s1_q     <= pad_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
        end
    end

    assign level_o = stable_q;
    assign evt_o   = evt_q;

`ifdef GPIO_COND_GLITCH_CNT_EN
    assign glitch_c = (s2_q == stable_q) && (cnt_q != '0);
`endif

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: shared debounce prescaler, per-pin debounce, sticky edge irq status.
// GPIO_COND_GLITCH_CNT_EN adds a saturating 8-bit rejected-glitch counter output.
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH    = GPIO_WIDTH,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned DB_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] dir,
    input  logic [WIDTH-1:0] irq_rise_en,
    input  logic [WIDTH-1:0] irq_fall_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] pin_level,
    output logic [WIDTH-1:0] rise_evt,
    output logic [WIDTH-1:0] fall_evt,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
`ifdef GPIO_COND_GLITCH_CNT_EN
    ,
    output logic [7:0]       glitch_cnt
`endif
);

    localparam int unsigned PW = cnt_width(PRESCALE);

    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic             tick;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_q;
    logic [WIDTH-1:0] irq_d;

    // With PRESCALE=1 the counter sits at 0, which is also the wrap value, so tick stays high.
    always_comb begin
        tick  = (pre_q == PW'(PRESCALE - 1));
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

`ifdef GPIO_COND_GLITCH_CNT_EN
    logic [WIDTH-1:0] glitch;
`endif

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin
        edge_evt_t evt;

        gpio_debounce_bit #(
            .DB_COUNT (DB_COUNT)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .pad_i    (pad_in[i]),
            .dir_i    (dir[i]),
            .tick_i   (tick),
            .level_o  (level[i]),
            .evt_o    (evt)
`ifdef GPIO_COND_GLITCH_CNT_EN
            ,
            .glitch_c (glitch[i])
`endif
        );

        assign rise[i] = evt.rise;
        assign fall[i] = evt.fall;
    end

    // Set has priority over a same-cycle write-1-to-clear.
    always_comb begin
        irq_d = (irq_q & ~irq_clr) | (rise & irq_rise_en) | (fall & irq_fall_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            irq_q <= '0;
        end else begin
            pre_q <= pre_d;
            irq_q <= irq_d;
        end
    end

    assign pin_level  = level;
    assign rise_evt   = rise;
    assign fall_evt   = fall;
    assign irq_status = irq_q;
    assign irq        = |irq_q;

`ifdef GPIO_COND_GLITCH_CNT_EN
    localparam int unsigned SW = 9 + cnt_width(WIDTH + 1);

    logic [SW-1:0] gsum;
    logic [7:0]    gcnt_q;
    logic [7:0]    gcnt_d;

    // Add this cycle's rejecting pins, clamp at 255.
    always_comb begin
        gsum = SW'(gcnt_q);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            gsum = gsum + SW'(glitch[i]);
        end
        gcnt_d = (gsum > SW'(255)) ? 8'hFF : gsum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt = gcnt_q;
`endif

endmodule
